sinewave_rom: RTL and testbench

//   Synchronous 64-entry, 8-bit sine look-up ROM feeding the FSK DAC path.
//   The upstream phase counter drives one period per 64 addresses; the ROM returns an

---
 rtl/sinewave_pkg.sv | 14 +
 rtl/sine_quarter_lut.sv | 37 +++
 rtl/sinewave_rom.sv | 105 ++++++++++
 tb/tb_sinewave_rom.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sinewave_pkg.sv
// Shared widths, constants and types for the sine look-up ROM.
package sinewave_pkg;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned QIDX_W    = 5;
    localparam logic [7:0]  MIDSCALE  = 8'd128;
    localparam logic [7:0]  AMPLITUDE = 8'd127;

    typedef logic [ADDR_W-1:0] phase_t;
    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [QIDX_W-1:0] qidx_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine table: Q[k] = 128 + round(127*sin(2*pi*k/64)), k = 0..16.
// Ports:
//   idx    in  5-bit quarter index, legal range 0..16
//   sample out offset-binary sample (combinational)
module sine_quarter_lut
    import sinewave_pkg::*;
(
    input  qidx_t   idx,
    output sample_t sample
);

    // Rising quarter of the waveform; indices above 16 never occur.
    always_comb begin
        sample = MIDSCALE;
        case (idx)
            5'd0:    sample = 8'd128;
            5'd1:    sample = 8'd140;
            5'd2:    sample = 8'd153;
            5'd3:    sample = 8'd165;
            5'd4:    sample = 8'd177;
            5'd5:    sample = 8'd188;
            5'd6:    sample = 8'd199;
            5'd7:    sample = 8'd209;
            5'd8:    sample = 8'd218;
            5'd9:    sample = 8'd226;
            5'd10:   sample = 8'd234;
            5'd11:   sample = 8'd240;
            5'd12:   sample = 8'd245;
            5'd13:   sample = 8'd250;
            5'd14:   sample = 8'd253;
            5'd15:   sample = 8'd254;
            5'd16:   sample = 8'd255;
            default: sample = MIDSCALE;
        endcase
    end

endmodule

// File: rtl/sinewave_rom.sv
// 64-entry, 8-bit offset-binary sine ROM with one cycle of address latency.
// Optional macro SINEWAVE_ROM_QUARTER_EN: store only a quarter-wave table and
// rebuild the other three quadrants by mirroring; output is bit-identical.
// Ports:
//   clock   in  single clock, all updates on posedge
//   rst_n   in  synchronous active-low reset (forces q to midscale next edge)
//   address in  phase index 0..63
//   q       out sample for the address registered on the previous edge
module sinewave_rom #(
    parameter int unsigned ADDR_W = sinewave_pkg::ADDR_W,
    parameter int unsigned DATA_W = sinewave_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] q
);

    import sinewave_pkg::*;

    // Only the 64 x 8 geometry has a table behind it.
    if (ADDR_W != 6 || DATA_W != 8) begin : g_bad_geometry
        $error("sinewave_rom supports only ADDR_W=6 and DATA_W=8");
    end

    phase_t addr_q;

    // Address register; reset selects entry 0 (midscale).
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= phase_t'(address);
        end
    end

`ifdef SINEWAVE_ROM_QUARTER_EN
    logic    half;
    qidx_t   idx;
    sample_t quarter_sample;

    // Second quarter of each half mirrors the first around index 16.
    always_comb begin
        half = addr_q[5];
        idx  = addr_q[4] ? QIDX_W'(6'd32 - {1'b0, addr_q[4:0]}) : addr_q[4:0];
    end

    sine_quarter_lut u_quarter_lut (
        .idx    (idx),
        .sample (quarter_sample)
    );

    // Negative half is the positive half reflected about midscale.
    always_comb begin
        q = half ? DATA_W'(9'd256 - {1'b0, quarter_sample}) : DATA_W'(quarter_sample);
    end
`else
    sample_t sample;

    // Full-period table indexed directly by the registered address.
    always_comb begin
        sample = MIDSCALE;
        case (addr_q)
            6'd0:  sample = 8'd128;  6'd1:  sample = 8'd140;
            6'd2:  sample = 8'd153;  6'd3:  sample = 8'd165;
            6'd4:  sample = 8'd177;  6'd5:  sample = 8'd188;
            6'd6:  sample = 8'd199;  6'd7:  sample = 8'd209;
            6'd8:  sample = 8'd218;  6'd9:  sample = 8'd226;
            6'd10: sample = 8'd234;  6'd11: sample = 8'd240;
            6'd12: sample = 8'd245;  6'd13: sample = 8'd250;
            6'd14: sample = 8'd253;  6'd15: sample = 8'd254;
            6'd16: sample = 8'd255;  6'd17: sample = 8'd254;
            6'd18: sample = 8'd253;  6'd19: sample = 8'd250;
            6'd20: sample = 8'd245;  6'd21: sample = 8'd240;
            6'd22: sample = 8'd234;  6'd23: sample = 8'd226;
            6'd24: sample = 8'd218;  6'd25: sample = 8'd209;
            6'd26: sample = 8'd199;  6'd27: sample = 8'd188;
            6'd28: sample = 8'd177;  6'd29: sample = 8'd165;
            6'd30: sample = 8'd153;  6'd31: sample = 8'd140;
            6'd32: sample = 8'd128;  6'd33: sample = 8'd116;
            6'd34: sample = 8'd103;  6'd35: sample = 8'd91;
            6'd36: sample = 8'd79;   6'd37: sample = 8'd68;
            6'd38: sample = 8'd57;   6'd39: sample = 8'd47;
            6'd40: sample = 8'd38;   6'd41: sample = 8'd30;
            6'd42: sample = 8'd22;   6'd43: sample = 8'd16;
            6'd44: sample = 8'd11;   6'd45: sample = 8'd6;
            6'd46: sample = 8'd3;    6'd47: sample = 8'd2;
            6'd48: sample = 8'd1;    6'd49: sample = 8'd2;
            6'd50: sample = 8'd3;    6'd51: sample = 8'd6;
            6'd52: sample = 8'd11;   6'd53: sample = 8'd16;
            6'd54: sample = 8'd22;   6'd55: sample = 8'd30;
            6'd56: sample = 8'd38;   6'd57: sample = 8'd47;
            6'd58: sample = 8'd57;   6'd59: sample = 8'd68;
            6'd60: sample = 8'd79;   6'd61: sample = 8'd91;
            6'd62: sample = 8'd103;  6'd63: sample = 8'd116;
            default: sample = MIDSCALE;
        endcase
    end

    always_comb begin
        q = DATA_W'(sample);
    end
`endif

endmodule

// File: tb/tb_sinewave_rom.sv
// Scoreboarded bench for sinewave_rom: stimulus pushes expected samples computed
// from the sine formula; a monitor pops and compares one edge later.
module tb_sinewave_rom;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] address = 6'd0;
    logic [7:0] q;

    typedef struct {
        int   exp_val;
        int   key_val;   // hand-listed key point, -1 when none
        bit   in_sweep;  // contributes to the min/max extremum check
        int   addr;
        bit   rst;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int vectors    = 0;
    int miscompares = 0;
    int obs_min = 1000;
    int obs_max = -1;
    bit stim_done = 1'b0;

    sinewave_rom dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .address (address),
        .q       (q)
    );

    always #5 clock = ~clock;

    // Reference: 128 + round-half-away-from-zero(127*sin(2*pi*a/64)).
    function automatic int model(input int a);
        real v;
        real r;
        v = 127.0 * $sin(2.0 * 3.14159265358979323846 * a / 64.0);
        if (v >= 0.0) r = $floor(v + 0.5);
        else          r = -$floor(-v + 0.5);
        return 128 + int'(r);
    endfunction

    function automatic int key_point(input int a);
        case (a)
            0:  return 128;
            1:  return 140;
            8:  return 218;
            16: return 255;
            32: return 128;
            40: return 38;
            48: return 1;
            63: return 116;
            default: return -1;
        endcase
    endfunction

    // Apply inputs just after an edge, then record what the next edge must produce.
    task automatic apply(input int a, input bit rst, input bit sweep);
        sb_entry_t e;
        address = 6'(a);
        rst_n   = ~rst;
        @(posedge clock);
        e.addr     = a;
        e.rst      = rst;
        e.in_sweep = sweep && !rst;
        e.exp_val  = rst ? 128 : model(a);
        e.key_val  = rst ? 128 : key_point(a);
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: compare q a few ns after each edge for every pending expectation.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (int'(q) != e.exp_val) begin
                    miscompares++;
                    $display("FAIL q_model addr=%0d rst=%0d got=%0d want=%0d", e.addr, e.rst, q, e.exp_val);
                end
                if (e.key_val >= 0) begin
                    vectors++;
                    if (int'(q) != e.key_val) begin
                        miscompares++;
                        $display("FAIL q_keypoint addr=%0d rst=%0d got=%0d want=%0d", e.addr, e.rst, q, e.key_val);
                    end
                end
                if (e.in_sweep) begin
                    if (int'(q) < obs_min) obs_min = int'(q);
                    if (int'(q) > obs_max) obs_max = int'(q);
                end
            end
        end
    end

    initial begin
        int n;
        #1;
        // Reset held for two edges with a non-zero address, then release.
        apply(37, 1'b1, 1'b0);
        apply(37, 1'b1, 1'b0);
        apply(37, 1'b0, 1'b0);
        // Full sweep, one address per cycle.
        for (int a = 0; a < 64; a++) apply(a, 1'b0, 1'b1);
        // Wrap 63 -> 0.
        apply(63, 1'b0, 1'b0);
        apply(0, 1'b0, 1'b0);
        apply(63, 1'b0, 1'b0);
        apply(0, 1'b0, 1'b0);
        // Reset pulse mid-sweep at address 20.
        for (int a = 10; a < 31; a++) apply(a, (a == 20), 1'b0);
        // Random addresses with occasional reset.
        for (int i = 0; i < 300; i++) begin
            apply(int'($urandom_range(63, 0)), ($urandom_range(15, 0) == 0), 1'b0);
        end
        stim_done = 1'b1;
        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        #5;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        vectors++;
        if (obs_max != 255) begin
            miscompares++;
            $display("FAIL sweep_max got=%0d want=255", obs_max);
        end
        vectors++;
        if (obs_min != 1) begin
            miscompares++;
            $display("FAIL sweep_min got=%0d want=1", obs_min);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
